// File: rtl/pipe_rr_arbiter.sv
// Round-robin share of one valid-only pipeline among NUM_REQ requesters; a tag shelf routes results home.
// Latency: grant is combinational; response appears LATENCY cycles after its grant.
// Backpressure: none downstream; requesters simply wait (req_ready low) until they win. Optional macro PIPE_RR_ARBITER_TAG_CHECK_EN.
module pipe_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         pipe_x,
  output logic                      pipe_input_valid,
  input  logic [DATA_W-1:0]         pipe_out,
  input  logic                      pipe_output_valid,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id,
  output logic                      idle,
  output logic                      err
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_id;
  logic               found;
  logic               grant;
  logic [LATENCY-1:0] shelf_v;
  logic [ID_W-1:0]    shelf_id [LATENCY];
  logic               tail_v;
  logic [ID_W-1:0]    tail_id;

  // Search for the first valid requester starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

  // Reset also masks the grant so nothing leaks out while rst is held.
  assign grant = arb_en & found & ~rst;

  // Drive the grant vector and the winning operand; everything zero when no grant.
  always_comb begin
    req_ready        = '0;
    pipe_x           = '0;
    pipe_input_valid = 1'b0;
    if (grant) begin
      req_ready        = NUM_REQ'(1) << gnt_id;
      pipe_x           = req_data[gnt_id*DATA_W +: DATA_W];
      pipe_input_valid = 1'b1;
    end
  end

  // Advance the round-robin pointer past the winner; hold it when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  // Tag shelf mirrors the pipeline: shifts every cycle since the pipeline never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shelf_v <= '0;
      for (int k = 0; k < LATENCY; k++) shelf_id[k] <= '0;
    end else begin
      shelf_v[0]  <= pipe_input_valid;
      shelf_id[0] <= gnt_id;
      for (int k = 1; k < LATENCY; k++) begin
        shelf_v[k]  <= shelf_v[k-1];
        shelf_id[k] <= shelf_id[k-1];
      end
    end
  end

  assign tail_v  = shelf_v[LATENCY-1];
  assign tail_id = shelf_id[LATENCY-1];

  // Route the pipeline result to the requester recorded at the shelf tail.
  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    resp_id    = '0;
    if (pipe_output_valid && !rst) begin
      resp_valid = NUM_REQ'(1) << tail_id;
      resp_data  = pipe_out;
      resp_id    = tail_id;
    end
  end

  assign idle = ~|shelf_v & ~pipe_input_valid;

`ifdef PIPE_RR_ARBITER_TAG_CHECK_EN
  // Sticky flag: the pipeline's valid must always agree with our own record of what is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (pipe_output_valid != tail_v) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_tail_v;
  assign unused_tail_v = tail_v;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Directed bench for pipe_rr_arbiter with a one-stage x+1 pipeline model.
// Inputs change 1ns after posedge; outputs are sampled on the falling edge.
// Expected values are hand-computed from the round-robin rules.
module tb_pipe_rr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic           clk;
  logic           rst;
  logic           arb_en;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic [DW-1:0]  pipe_x;
  logic           pipe_input_valid;
  logic [DW-1:0]  pipe_out;
  logic           pipe_output_valid;
  logic [NR-1:0]  resp_valid;
  logic [DW-1:0]  resp_data;
  logic [1:0]     resp_id;
  logic           idle;
  logic           err;

  logic           model_v;
  logic           force_ov;

  int n_cmp;
  int n_bad;

  pipe_rr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LATENCY(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .arb_en            (arb_en),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .pipe_x            (pipe_x),
    .pipe_input_valid  (pipe_input_valid),
    .pipe_out          (pipe_out),
    .pipe_output_valid (pipe_output_valid),
    .resp_valid        (resp_valid),
    .resp_data         (resp_data),
    .resp_id           (resp_id),
    .idle              (idle),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-stage pipeline model computing x+1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_v  <= 1'b0;
      pipe_out <= '0;
    end else begin
      model_v  <= pipe_input_valid;
      pipe_out <= pipe_x + 32'd1;
    end
  end

  assign pipe_output_valid = model_v | force_ov;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] g;
    logic [1:0] p;
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b0;
    arb_en    = 1'b1;
    req_valid = 4'b1111;
    req_data  = '0;
    force_ov  = 1'b0;

    // 1. asynchronous reset mid-cycle with requests pending
    #3 rst = 1'b1;
    #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'h0);
    check_eq("rst_piv", 64'(pipe_input_valid), 64'h0);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'h0);
    check_eq("rst_idle", 64'(idle), 64'h1);
    check_eq("rst_err", 64'(err), 64'h0);
    next_cycle();
    req_valid = '0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_idle0", 64'(idle), 64'h1);
    next_cycle();
    @(negedge clk);
    check_eq("rel_idle1", 64'(idle), 64'h1);
    check_eq("rel_req_ready", 64'(req_ready), 64'h0);

    // 2. single requester, data 0x10 -> response 0x11 one cycle later
    next_cycle();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 32'h10;
    @(negedge clk);
    check_eq("single_ready", 64'(req_ready), 64'h4);
    check_eq("single_x", 64'(pipe_x), 64'h10);
    check_eq("single_piv", 64'(pipe_input_valid), 64'h1);
    check_eq("single_idle", 64'(idle), 64'h0);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check_eq("single_resp_valid", 64'(resp_valid), 64'h4);
    check_eq("single_resp_id", 64'(resp_id), 64'h2);
    check_eq("single_resp_data", 64'(resp_data), 64'h11);
    check_eq("single_ready_off", 64'(req_ready), 64'h0);
    next_cycle();
    @(negedge clk);
    check_eq("single_done_idle", 64'(idle), 64'h1);
    check_eq("single_done_resp", 64'(resp_valid), 64'h0);

    // rr_ptr is 3 now: granting requester 3 must wrap the pointer to 0
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'h100 + 32'(i);
    next_cycle();
    req_valid = 4'b1000;
    @(negedge clk);
    check_eq("wrap3_ready", 64'(req_ready), 64'h8);

    // 3. full contention: grants 0,1,2,3,0,1,2,3; each response is the previous grant
    for (int j = 0; j < 8; j++) begin
      next_cycle();
      req_valid = 4'b1111;
      g = 2'(j);
      p = 2'(j + 3);
      @(negedge clk);
      check_eq($sformatf("rr_ready%0d", j), 64'(req_ready), 64'(4'b0001 << g));
      check_eq($sformatf("rr_x%0d", j), 64'(pipe_x), 64'h100 + 64'(g));
      check_eq($sformatf("rr_resp_id%0d", j), 64'(resp_id), 64'(p));
      check_eq($sformatf("rr_resp_data%0d", j), 64'(resp_data), 64'h101 + 64'(p));
      check_eq($sformatf("rr_resp_valid%0d", j), 64'(resp_valid), 64'(4'b0001 << p));
    end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check_eq("rr_last_id", 64'(resp_id), 64'h3);
    check_eq("rr_last_valid", 64'(resp_valid), 64'h8);

    // 4. pointer to 3 via grant 2, then 0011 -> 0, 1, 0
    next_cycle();
    req_valid = 4'b0100;
    @(negedge clk);
    check_eq("skip_pre_ready", 64'(req_ready), 64'h4);
    next_cycle();
    req_valid = 4'b0011;
    @(negedge clk);
    check_eq("skip_g0", 64'(req_ready), 64'h1);
    check_eq("skip_g0_resp", 64'(resp_id), 64'h2);
    next_cycle();
    @(negedge clk);
    check_eq("skip_g1", 64'(req_ready), 64'h2);
    check_eq("skip_g1_resp", 64'(resp_data), 64'h101);
    next_cycle();
    @(negedge clk);
    check_eq("skip_g2", 64'(req_ready), 64'h1);
    check_eq("skip_g2_resp", 64'(resp_id), 64'h1);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check_eq("skip_tail_resp", 64'(resp_valid), 64'h1);

    // 5. arb_en low drains in-flight work; pointer held (1 -> grant 2 -> ptr 3)
    next_cycle();
    req_valid = 4'b0100;
    @(negedge clk);
    check_eq("en_pre_ready", 64'(req_ready), 64'h4);
    next_cycle();
    arb_en    = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    check_eq("en_off_ready", 64'(req_ready), 64'h0);
    check_eq("en_off_piv", 64'(pipe_input_valid), 64'h0);
    check_eq("en_off_x", 64'(pipe_x), 64'h0);
    check_eq("en_off_resp", 64'(resp_valid), 64'h4);
    check_eq("en_off_data", 64'(resp_data), 64'h103);
    check_eq("en_off_busy", 64'(idle), 64'h0);
    next_cycle();
    @(negedge clk);
    check_eq("en_off_idle", 64'(idle), 64'h1);
    check_eq("en_off_noresp", 64'(resp_valid), 64'h0);
    next_cycle();
    arb_en = 1'b1;
    @(negedge clk);
    check_eq("en_on_g3", 64'(req_ready), 64'h8);
    next_cycle();
    @(negedge clk);
    check_eq("en_on_g0", 64'(req_ready), 64'h1);
    next_cycle();
    req_valid = '0;
    next_cycle();
    next_cycle();

    // 6. pipeline valid with an empty shelf tail
    @(negedge clk);
    check_eq("chk_err_before", 64'(err), 64'h0);
    next_cycle();
    force_ov = 1'b1;
    @(negedge clk);
    check_eq("chk_err_same_cycle", 64'(err), 64'h0);
    next_cycle();
    force_ov = 1'b0;
    @(negedge clk);
`ifdef PIPE_RR_ARBITER_TAG_CHECK_EN
    check_eq("chk_err_set", 64'(err), 64'h1);
    next_cycle();
    @(negedge clk);
    check_eq("chk_err_sticky", 64'(err), 64'h1);
`else
    check_eq("chk_err_tied", 64'(err), 64'h0);
    next_cycle();
    @(negedge clk);
    check_eq("chk_err_tied2", 64'(err), 64'h0);
`endif
    next_cycle();
    rst = 1'b1;
    #1;
    check_eq("chk_err_rst", 64'(err), 64'h0);
    check_eq("chk_idle_rst", 64'(idle), 64'h1);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_rr_arbiter.md
Name: pipe_rr_arbiter

Overview:
Round-robin arbiter that shares one generated valid-only pipeline (no backpressure, fixed depth LATENCY) among NUM_REQ requesters. One request is granted per cycle and driven into the pipeline's x/input_valid. A tag shelf of LATENCY stages tracks the requester ID of each in-flight transaction and routes the pipeline's out/output_valid back to the originating requester. It sits between client blocks and the pipeline top (ports clk, rst, x, input_valid, out, output_valid).

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 32, pipeline operand/result width
LATENCY, 1, pipeline depth in cycles from input_valid to output_valid (>=1)
ID_W, $clog2(NUM_REQ), requester ID width (derived)

Ports:
clk  input  1  clock, all flops on posedge
rst  input  1  reset, asynchronous, active-high
arb_en  input  1  grant enable; low = no new grants, in-flight work drains
req_valid  input  NUM_REQ  per-requester request valid
req_data  input  NUM_REQ*DATA_W  per-requester operand, requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant, combinational
pipe_x  output  DATA_W  operand to pipeline x
pipe_input_valid  output  1  to pipeline input_valid
pipe_out  input  DATA_W  from pipeline out
pipe_output_valid  input  1  from pipeline output_valid
resp_valid  output  NUM_REQ  one-hot response strobe
resp_data  output  DATA_W  response data, shared by all requesters
resp_id  output  ID_W  ID of current response
idle  output  1  high when no transaction in flight and no grant this cycle
err  output  1  sticky tag/pipeline mismatch flag (see Optional Feature)

Behaviour:
- Reset (async assert): rr_ptr=0, all tag-shelf valid bits=0, err=0. While rst is high: req_ready=0, pipe_input_valid=0, resp_valid=0, idle=1.
- Grant: when arb_en=1, the first i with req_valid[i]=1 is chosen, searching from rr_ptr upward and wrapping at NUM_REQ. req_ready[i]=1, pipe_input_valid=1, pipe_x=req_data[i]. A transfer occurs when req_valid&req_ready.
- No valid request or arb_en=0: req_ready=0, pipe_input_valid=0, pipe_x=0.
- rr_ptr updates only on a grant, to (i+1) mod NUM_REQ; otherwise it holds. Wrap: a grant to NUM_REQ-1 sets rr_ptr=0.
- Requesters hold req_valid/req_data stable until granted. The arbiter never depends on a request being dropped.
- Tag shelf: shift register of LATENCY entries {v, id}. Every cycle stage0 <= {pipe_input_valid, granted_id} and stage k <= stage k-1. The shelf shifts unconditionally because the pipeline cannot stall.
- Response (combinational from shelf tail and pipeline outputs): when pipe_output_valid=1, resp_valid = onehot(tail.id), resp_data=pipe_out, resp_id=tail.id. Otherwise resp_valid=0; resp_data and resp_id are don't-care and are driven 0.
- Latency: grant in cycle N gives resp_valid in cycle N+LATENCY. Throughput is one transaction per cycle. Ordering follows grant order.
- Requesters accept responses unconditionally; there is no response backpressure.
- idle = ~|shelf.v & ~pipe_input_valid.
- Simultaneous grant and response in the same cycle are independent, with no hazard.
- Reset mid-operation clears the shelf, so late pipeline outputs after reset are not routed. The pipeline's own rst clears its valid; both resets are driven from the same rst.

Optional Feature:
Macro PIPE_RR_ARBITER_TAG_CHECK_EN.
- Defined: each cycle, if pipe_output_valid != tail.v, err is set to 1 and stays 1 until rst. Response routing still uses tail.id, gated by pipe_output_valid.
- Undefined: no check logic; err is tied to 0.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle -> req_ready=0, pipe_input_valid=0, resp_valid=0, idle=1 immediately. Release with all req_valid=0 -> idle stays 1.
2. Single requester: req_valid=4'b0100, req_data[2]=32'h10, LATENCY=1, pipeline x+1 -> req_ready=4'b0100 in cycle N; resp_valid=4'b0100, resp_id=2, resp_data=32'h11 in cycle N+1.
3. Full contention: req_valid=4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses arrive in the same order one cycle later with data+1.
4. Wrap/skip: rr_ptr=3, req_valid=4'b0011 -> grant 0, then 1, then 0. Granting requester 3 with rr_ptr=3 sets rr_ptr=0.
5. arb_en low: deassert arb_en with 1 transaction in flight -> no new req_ready, in-flight response still delivered, idle=1 the next cycle. Reassert -> grants resume from the held rr_ptr.
6. With PIPE_RR_ARBITER_TAG_CHECK_EN: force pipe_output_valid=1 while shelf tail v=0 -> err=1 next cycle and stays 1 until rst. Without the macro, err=0.
